// File: rtl/level_loader_if.sv
// rtl/level_loader_if.sv - level loader request, ROM and map-write bundle
interface level_loader_if;
  logic       start;
  logic [2:0] level;
  logic [9:0] rom_addr;
  logic [3:0] rom_data;
  logic       wr_en;
  logic [3:0] wr_x;
  logic [3:0] wr_y;
  logic [3:0] wr_cur;
  logic [3:0] wr_env;
  logic [3:0] p_x;
  logic [3:0] p_y;
  logic [6:0] box_num;
  logic       busy;
  logic       ready;
  logic       err;

  // Game side: requests loads, supplies ROM data, consumes writes and results.
  modport master (
    output start, level, rom_data,
    input  rom_addr, wr_en, wr_x, wr_y, wr_cur, wr_env,
    input  p_x, p_y, box_num, busy, ready, err
  );

  // Loader side.
  modport slave (
    input  start, level, rom_data,
    output rom_addr, wr_en, wr_x, wr_y, wr_cur, wr_env,
    output p_x, p_y, box_num, busy, ready, err
  );
endinterface

// File: rtl/level_loader.sv
// rtl/level_loader.sv - streams one level from ROM into the current/environment maps
module level_loader #(
  parameter int         MAP_W          = 10,
  parameter int         MAP_H          = 10,
  parameter int         MAX_LEVEL      = 3,
  parameter int         ROM_LAT        = 2,
  parameter logic [3:0] CODE_GROUND    = 4'd0,
  parameter logic [3:0] CODE_TARGET    = 4'd2,
  parameter logic [3:0] CODE_BOX       = 4'd3,
  parameter logic [3:0] CODE_PLAYER    = 4'd4,
  parameter logic [3:0] CODE_PLAYER_UP = 4'd4
) (
  input logic           clk,
  input logic           rst_n,
  level_loader_if.slave bus
);

  localparam int CELLS = MAP_W * MAP_H;
  localparam int TL    = ROM_LAT - 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Flat ROM address of cell (x,y) within level lv (levels are 1-based).
  function automatic logic [9:0] cell_addr(input logic [2:0] lv, input logic [3:0] x,
                                           input logic [3:0] y);
    logic [9:0] lv_off;
    lv_off = 10'(lv) - 10'd1;
    return lv_off * 10'(CELLS) + 10'(y) * 10'(MAP_W) + 10'(x);
  endfunction

  logic [1:0] state_q, state_d;
  logic [2:0] level_q;
  logic [3:0] x_q, y_q, x_d, y_d;
  logic [9:0] rom_addr_q;

  logic       tag_v_q [ROM_LAT];
  logic [3:0] tag_x_q [ROM_LAT];
  logic [3:0] tag_y_q [ROM_LAT];
  logic       tags_busy;

  logic       wr_en_q;
  logic [3:0] wr_x_q, wr_y_q, wr_cur_q, wr_env_q;
  logic [3:0] p_x_q, p_y_q;
  logic [6:0] player_cnt_q, box_cnt_q, target_cnt_q;
  logic       busy_q, ready_q, err_q;

  logic level_ok, accept_ok, accept_bad, last_cell, bad_map;

  assign level_ok   = (bus.level != 3'd0) && (int'(bus.level) <= MAX_LEVEL);
  assign accept_ok  = (state_q == S_IDLE) && bus.start && level_ok;
  assign accept_bad = (state_q == S_IDLE) && bus.start && !level_ok;
  assign last_cell  = (x_q == 4'(MAP_W - 1)) && (y_q == 4'(MAP_H - 1));
  assign bad_map    = (player_cnt_q != 7'd1) || (box_cnt_q == 7'd0) ||
                      (box_cnt_q != target_cnt_q);

  // Any cell still in flight between address issue and the write register.
  always_comb begin
    tags_busy = 1'b0;
    for (int i = 0; i < ROM_LAT; i++) tags_busy = tags_busy | tag_v_q[i];
  end

  // Next scan position, x fastest.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (x_q == 4'(MAP_W - 1)) begin
      x_d = 4'd0;
      y_d = y_q + 4'd1;
    end else begin
      x_d = x_q + 4'd1;
    end
  end

  // Sequencer next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_ok) state_d = S_FETCH;
               else if (accept_bad) state_d = S_DONE;
      S_FETCH: if (last_cell) state_d = S_DRAIN;
      S_DRAIN: if (!tags_busy) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State plus status flags; ready/err pulse on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == S_FETCH) || (state_d == S_DRAIN);
      ready_q <= (state_d == S_DONE);
      err_q   <= accept_bad ||
                 ((state_q == S_DRAIN) && (state_d == S_DONE) && bad_map);
    end
  end

  // Address generator: first address on accept, then one per FETCH cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q    <= 3'd0;
      x_q        <= 4'd0;
      y_q        <= 4'd0;
      rom_addr_q <= 10'd0;
    end else if (accept_ok) begin
      level_q    <= bus.level;
      x_q        <= 4'd0;
      y_q        <= 4'd0;
      rom_addr_q <= cell_addr(bus.level, 4'd0, 4'd0);
    end else if ((state_q == S_FETCH) && !last_cell) begin
      x_q        <= x_d;
      y_q        <= y_d;
      rom_addr_q <= cell_addr(level_q, x_d, y_d);
    end
  end

  // Tag pipeline: carries each issued cell's position until its ROM data arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        tag_v_q[i] <= 1'b0;
        tag_x_q[i] <= 4'd0;
        tag_y_q[i] <= 4'd0;
      end
    end else begin
      tag_v_q[0] <= (state_q == S_FETCH);
      tag_x_q[0] <= x_q;
      tag_y_q[0] <= y_q;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_x_q[i] <= tag_x_q[i-1];
        tag_y_q[i] <= tag_y_q[i-1];
      end
    end
  end

  // Map write register plus player/box/target bookkeeping from arriving ROM data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q      <= 1'b0;
      wr_x_q       <= 4'd0;
      wr_y_q       <= 4'd0;
      wr_cur_q     <= 4'd0;
      wr_env_q     <= 4'd0;
      p_x_q        <= 4'd0;
      p_y_q        <= 4'd0;
      player_cnt_q <= 7'd0;
      box_cnt_q    <= 7'd0;
      target_cnt_q <= 7'd0;
    end else begin
      wr_en_q <= tag_v_q[TL];
      if (accept_ok) begin
        p_x_q        <= 4'd0;
        p_y_q        <= 4'd0;
        player_cnt_q <= 7'd0;
        box_cnt_q    <= 7'd0;
        target_cnt_q <= 7'd0;
      end else if (tag_v_q[TL]) begin
        wr_x_q <= tag_x_q[TL];
        wr_y_q <= tag_y_q[TL];
        if (bus.rom_data == CODE_PLAYER) begin
          wr_cur_q     <= CODE_PLAYER_UP;
          wr_env_q     <= CODE_GROUND;
          p_x_q        <= tag_x_q[TL];
          p_y_q        <= tag_y_q[TL];
          player_cnt_q <= player_cnt_q + 7'd1;
        end else if (bus.rom_data == CODE_BOX) begin
          wr_cur_q  <= CODE_BOX;
          wr_env_q  <= CODE_GROUND;
          box_cnt_q <= box_cnt_q + 7'd1;
        end else if (bus.rom_data == CODE_TARGET) begin
          wr_cur_q     <= CODE_TARGET;
          wr_env_q     <= CODE_TARGET;
          target_cnt_q <= target_cnt_q + 7'd1;
        end else begin
          wr_cur_q <= bus.rom_data;
          wr_env_q <= bus.rom_data;
        end
      end
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_x     = wr_x_q;
  assign bus.wr_y     = wr_y_q;
  assign bus.wr_cur   = wr_cur_q;
  assign bus.wr_env   = wr_env_q;
  assign bus.p_x      = p_x_q;
  assign bus.p_y      = p_y_q;
  assign bus.box_num  = box_cnt_q;
  assign bus.busy     = busy_q;
  assign bus.ready    = ready_q;
  assign bus.err      = err_q;

endmodule
